warp_mem_arbiter: RTL and testbench

Shares the single 64-bit memory port between instruction fetch and the load/store unit. Exactly one transaction is outstanding at a time. Grants are registered, and responses route back to the owning requester in the cycle they arrive. A bounded-starvation counter keeps fetch progressing under heavy data traffic. A flush input squashes in-flight fetch responses after a branch redirect.

---
 rtl/warp_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_warp_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/warp_mem_arbiter.sv
// warp_mem_arbiter: shares one 64-bit memory port between instruction fetch and
// the load/store unit, with one outstanding transaction and bounded fetch starvation.
module warp_mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,

    input  logic        i_if_req,
    input  logic [63:0] i_if_addr,
    output logic [63:0] o_if_rdata,
    output logic        o_if_valid,
    input  logic        i_flush,

    input  logic        i_ls_req,
    input  logic [63:0] i_ls_addr,
    input  logic        i_ls_wen,
    input  logic [63:0] i_ls_wdata,
    input  logic [7:0]  i_ls_wmask,
    output logic [63:0] o_ls_rdata,
    output logic        o_ls_valid,

    output logic        o_mem_req,
    output logic [63:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [63:0] o_mem_wdata,
    output logic [7:0]  o_mem_wmask,
    input  logic [63:0] i_mem_rdata,
    input  logic        i_mem_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } state_e;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_e      state_q, state_d;
    logic [3:0]  starveCnt_q, starveCnt_d;
    logic        drop_q, drop_d;
    logic [63:0] memAddr_q, memAddr_d;
    logic        memWen_q, memWen_d;
    logic [63:0] memWdata_q, memWdata_d;
    logic [7:0]  memWmask_q, memWmask_d;
    logic        grantIf, grantLs;

    // LS normally wins a tie; fetch wins once it has been passed over LIMIT times.
    always_comb begin
        grantIf = 1'b0;
        grantLs = 1'b0;
        if (state_q == IDLE) begin
            if (i_if_req && (!i_ls_req || (starveCnt_q == LIMIT))) begin
                grantIf = 1'b1;
            end else if (i_ls_req) begin
                grantLs = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        starveCnt_d = starveCnt_q;
        drop_d      = drop_q;
        memAddr_d   = memAddr_q;
        memWen_d    = memWen_q;
        memWdata_d  = memWdata_q;
        memWmask_d  = memWmask_q;
        case (state_q)
            IDLE: begin
                if (grantIf) begin
                    state_d     = BUSY_IF;
                    memAddr_d   = i_if_addr;
                    memWen_d    = 1'b0;
                    memWdata_d  = 64'd0;
                    memWmask_d  = 8'd0;
                    starveCnt_d = 4'd0;
                    drop_d      = i_flush;
                end else if (grantLs) begin
                    state_d    = BUSY_LS;
                    memAddr_d  = i_ls_addr;
                    memWen_d   = i_ls_wen;
                    memWdata_d = i_ls_wdata;
                    memWmask_d = i_ls_wmask;
                    if (i_if_req && (starveCnt_q < LIMIT)) begin
                        starveCnt_d = starveCnt_q + 4'd1;
                    end
                end
            end
            // A flushed fetch still completes on the memory side, only its strobe is hidden.
            BUSY_IF: begin
                if (i_mem_valid) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end else if (i_flush) begin
                    drop_d = 1'b1;
                end
            end
            BUSY_LS: begin
                if (i_mem_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            starveCnt_q <= 4'd0;
            drop_q      <= 1'b0;
            memAddr_q   <= 64'd0;
            memWen_q    <= 1'b0;
            memWdata_q  <= 64'd0;
            memWmask_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            starveCnt_q <= starveCnt_d;
            drop_q      <= drop_d;
            memAddr_q   <= memAddr_d;
            memWen_q    <= memWen_d;
            memWdata_q  <= memWdata_d;
            memWmask_q  <= memWmask_d;
        end
    end

    assign o_mem_req   = (state_q != IDLE);
    assign o_mem_addr  = memAddr_q;
    assign o_mem_wen   = memWen_q;
    assign o_mem_wdata = memWdata_q;
    assign o_mem_wmask = memWmask_q;

    assign o_if_rdata = i_mem_rdata;
    assign o_ls_rdata = i_mem_rdata;
    assign o_if_valid = i_mem_valid && (state_q == BUSY_IF) && !drop_q && !i_flush;
    assign o_ls_valid = i_mem_valid && (state_q == BUSY_LS);

endmodule

// File: tb/tb_warp_mem_arbiter.sv
// tb_warp_mem_arbiter: directed vector table plus hand-written multi-cycle
// sequences for starvation, flush, reset and back-to-back loads.
module tb_warp_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_if_req;
    logic [63:0] i_if_addr;
    logic [63:0] o_if_rdata;
    logic        o_if_valid;
    logic        i_flush;
    logic        i_ls_req;
    logic [63:0] i_ls_addr;
    logic        i_ls_wen;
    logic [63:0] i_ls_wdata;
    logic [7:0]  i_ls_wmask;
    logic [63:0] o_ls_rdata;
    logic        o_ls_valid;
    logic        o_mem_req;
    logic [63:0] o_mem_addr;
    logic        o_mem_wen;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wmask;
    logic [63:0] i_mem_rdata;
    logic        i_mem_valid;

    int vecCount  = 0;
    int missCount = 0;

    warp_mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .o_if_rdata  (o_if_rdata),
        .o_if_valid  (o_if_valid),
        .i_flush     (i_flush),
        .i_ls_req    (i_ls_req),
        .i_ls_addr   (i_ls_addr),
        .i_ls_wen    (i_ls_wen),
        .i_ls_wdata  (i_ls_wdata),
        .i_ls_wmask  (i_ls_wmask),
        .o_ls_rdata  (o_ls_rdata),
        .o_ls_valid  (o_ls_valid),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wen   (o_mem_wen),
        .o_mem_wdata (o_mem_wdata),
        .o_mem_wmask (o_mem_wmask),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_valid (i_mem_valid)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        ifReq;
        logic [63:0] ifAddr;
        logic        lsReq;
        logic [63:0] lsAddr;
        logic        lsWen;
        logic [63:0] lsWdata;
        logic [7:0]  lsWmask;
        logic        memValid;
        logic [63:0] memRdata;
        logic        eMemReq;
        logic [63:0] eMemAddr;
        logic        eMemWen;
        logic [63:0] eMemWdata;
        logic [7:0]  eMemWmask;
        logic        eIfValid;
        logic        eLsValid;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs[NV];

    localparam logic [63:0] A_IF = 64'h8000_0000_0000_0000;
    localparam logic [63:0] D_IF = 64'h1122_3344_5566_7788;
    localparam logic [63:0] D_ST = 64'h0000_0000_DEAD_BEEF;

    function automatic vec_t mkVec(
        input logic ifReq, input logic [63:0] ifAddr,
        input logic lsReq, input logic [63:0] lsAddr, input logic lsWen,
        input logic [63:0] lsWdata, input logic [7:0] lsWmask,
        input logic memValid, input logic [63:0] memRdata,
        input logic eMemReq, input logic [63:0] eMemAddr, input logic eMemWen,
        input logic [63:0] eMemWdata, input logic [7:0] eMemWmask,
        input logic eIfValid, input logic eLsValid);
        vec_t v;
        v.ifReq = ifReq;       v.ifAddr = ifAddr;
        v.lsReq = lsReq;       v.lsAddr = lsAddr;     v.lsWen = lsWen;
        v.lsWdata = lsWdata;   v.lsWmask = lsWmask;
        v.memValid = memValid; v.memRdata = memRdata;
        v.eMemReq = eMemReq;   v.eMemAddr = eMemAddr; v.eMemWen = eMemWen;
        v.eMemWdata = eMemWdata; v.eMemWmask = eMemWmask;
        v.eIfValid = eIfValid; v.eLsValid = eLsValid;
        return v;
    endfunction

    task automatic fillTable();
        // reset state, then fetch-only with a zero-wait ack
        vecs[0]  = mkVec(0, 0,     0, 0, 0, 0, 0,  0, 0,      0, 0,     0, 0, 0,  0, 0);
        vecs[1]  = mkVec(1, A_IF,  0, 0, 0, 0, 0,  0, 0,      0, 0,     0, 0, 0,  0, 0);
        vecs[2]  = mkVec(1, A_IF,  0, 0, 0, 0, 0,  1, D_IF,   1, A_IF,  0, 0, 0,  1, 0);
        vecs[3]  = mkVec(0, 0,     0, 0, 0, 0, 0,  0, 0,      0, A_IF,  0, 0, 0,  0, 0);
        // store with one wait cycle; registers hold after completion
        vecs[4]  = mkVec(0, 0,     1, 64'h1000, 1, D_ST, 8'h0F,  0, 0,  0, A_IF, 0, 0, 0,  0, 0);
        vecs[5]  = mkVec(0, 0,     1, 64'h1000, 1, D_ST, 8'h0F,  0, 0,  1, 64'h1000, 1, D_ST, 8'h0F,  0, 0);
        vecs[6]  = mkVec(0, 0,     1, 64'h1000, 1, D_ST, 8'h0F,  1, 0,  1, 64'h1000, 1, D_ST, 8'h0F,  0, 1);
        vecs[7]  = mkVec(0, 0,     0, 0, 0, 0, 0,  0, 0,      0, 64'h1000, 1, D_ST, 8'h0F,  0, 0);
        // requests arriving with the ack are only sampled once IDLE
        vecs[8]  = mkVec(1, 64'h40, 0, 0, 0, 0, 0, 0, 0,      0, 64'h1000, 1, D_ST, 8'h0F,  0, 0);
        vecs[9]  = mkVec(1, 64'h40, 1, 64'h2008, 0, 0, 0,  1, 64'hAAAA,  1, 64'h40, 0, 0, 0,  1, 0);
        vecs[10] = mkVec(0, 0,     1, 64'h2008, 0, 0, 0,  0, 0,  0, 64'h40, 0, 0, 0,  0, 0);
        vecs[11] = mkVec(0, 0,     1, 64'h2008, 0, 0, 0,  1, 64'h55,  1, 64'h2008, 0, 0, 0,  0, 1);
        vecs[12] = mkVec(0, 0,     0, 0, 0, 0, 0,  0, 0,      0, 64'h2008, 0, 0, 0,  0, 0);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clearInputs();
        i_if_req = 0; i_if_addr = 0; i_flush = 0;
        i_ls_req = 0; i_ls_addr = 0; i_ls_wen = 0; i_ls_wdata = 0; i_ls_wmask = 0;
        i_mem_valid = 0; i_mem_rdata = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        i_if_req    = v.ifReq;
        i_if_addr   = v.ifAddr;
        i_flush     = 1'b0;
        i_ls_req    = v.lsReq;
        i_ls_addr   = v.lsAddr;
        i_ls_wen    = v.lsWen;
        i_ls_wdata  = v.lsWdata;
        i_ls_wmask  = v.lsWmask;
        i_mem_valid = v.memValid;
        i_mem_rdata = v.memRdata;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkVector(input int idx, input vec_t v);
        logic [267:0] got, exp;
        got = {o_mem_req, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_wmask,
               o_if_valid, o_ls_valid, o_if_rdata, o_ls_rdata};
        exp = {v.eMemReq, v.eMemAddr, v.eMemWen, v.eMemWdata, v.eMemWmask,
               v.eIfValid, v.eLsValid, v.memRdata, v.memRdata};
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL vec%0d: got 0x%0h, expected 0x%0h", idx, got, exp);
        end
    endtask

    // Both requesters hold req, memory acks every request immediately; bit i of
    // expIf says whether grant i should go to fetch.
    task automatic runArbitration(input string tag, input int n, input logic [15:0] expIf);
        int got = 0;
        int budget = 0;
        i_if_req = 1; i_if_addr = 64'h9000;
        i_ls_req = 1; i_ls_addr = 64'hA000; i_ls_wen = 0; i_ls_wdata = 0; i_ls_wmask = 0;
        while (got < n && budget < 4 * n + 8) begin
            i_mem_valid = o_mem_req;
            i_mem_rdata = 64'(budget);
            @(negedge i_clk);
            if (o_if_valid || o_ls_valid) begin
                checkOutput($sformatf("%s_grant%0d", tag, got), {63'd0, o_if_valid}, {63'd0, expIf[got]});
                got++;
            end
            budget++;
            step();
        end
        if (got < n) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL %s_timeout: got %0d grants, expected %0d", tag, got, n);
        end
        clearInputs();
    endtask

    initial begin
        int got;
        int cyc;
        int lastValid;
        logic prevReq;

        clearInputs();
        i_rst_n = 0;
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1;

        fillTable();
        for (int i = 0; i < NV; i++) begin
            applyStimulus(vecs[i]);
            @(negedge i_clk);
            checkVector(i, vecs[i]);
            step();
        end
        clearInputs();

        $display("[TB] starvation sequence");
        runArbitration("starve", 6, 16'b0000_0000_0001_0000);

        $display("[TB] flush after IF grant");
        i_if_req = 1; i_if_addr = 64'h3000;
        @(negedge i_clk); step();
        i_flush = 1;
        @(negedge i_clk);
        checkOutput("flushBusyReq", o_mem_req, 1);
        step();
        i_flush = 0; i_if_req = 0;
        @(negedge i_clk); step();
        @(negedge i_clk); step();
        i_mem_valid = 1; i_mem_rdata = 64'h77;
        @(negedge i_clk);
        checkOutput("flushAckReq", o_mem_req, 1);
        checkOutput("flushIfValid", o_if_valid, 0);
        checkOutput("flushLsValid", o_ls_valid, 0);
        step();
        i_mem_valid = 0; i_if_req = 1; i_if_addr = 64'h2000;
        @(negedge i_clk);
        checkOutput("flushIdle", o_mem_req, 0);
        step();
        i_mem_valid = 1; i_mem_rdata = 64'hCAFE;
        @(negedge i_clk);
        checkOutput("postFlushAddr", o_mem_addr, 64'h2000);
        checkOutput("postFlushValid", o_if_valid, 1);
        checkOutput("postFlushRdata", o_if_rdata, 64'hCAFE);
        step();
        clearInputs();

        $display("[TB] flush on the IDLE grant cycle");
        i_if_req = 1; i_if_addr = 64'h4000; i_flush = 1;
        @(negedge i_clk); step();
        i_flush = 0; i_if_req = 0; i_mem_valid = 1; i_mem_rdata = 64'h44;
        @(negedge i_clk);
        checkOutput("grantFlushAddr", o_mem_addr, 64'h4000);
        checkOutput("grantFlushValid", o_if_valid, 0);
        step();
        clearInputs();

        $display("[TB] flush while LS owns the port");
        i_ls_req = 1; i_ls_addr = 64'h6000;
        @(negedge i_clk); step();
        i_flush = 1; i_mem_valid = 1; i_mem_rdata = 64'h66;
        @(negedge i_clk);
        checkOutput("lsFlushValid", o_ls_valid, 1);
        checkOutput("lsFlushRdata", o_ls_rdata, 64'h66);
        step();
        clearInputs();

        $display("[TB] reset during an LS transaction");
        i_ls_req = 1; i_ls_addr = 64'h5000; i_ls_wen = 1; i_ls_wdata = 64'h1234; i_ls_wmask = 8'hF0;
        @(negedge i_clk); step();
        i_mem_valid = 1; i_mem_rdata = 64'h99;
        checkOutput("preResetReq", o_mem_req, 1);
        #1;
        i_rst_n = 0;
        #1;
        checkOutput("rstReq", o_mem_req, 0);
        checkOutput("rstAddr", o_mem_addr, 0);
        checkOutput("rstWen", o_mem_wen, 0);
        checkOutput("rstWdata", o_mem_wdata, 0);
        checkOutput("rstWmask", o_mem_wmask, 0);
        checkOutput("rstLsValid", o_ls_valid, 0);
        i_mem_valid = 0;
        step();
        i_rst_n = 1; i_ls_wen = 0;
        @(negedge i_clk);
        checkOutput("rstReleaseReq", o_mem_req, 0);
        step();
        i_mem_valid = 1; i_mem_rdata = 64'hAB;
        @(negedge i_clk);
        checkOutput("rstFreshAddr", o_mem_addr, 64'h5000);
        checkOutput("rstFreshValid", o_ls_valid, 1);
        step();
        clearInputs();

        $display("[TB] back-to-back loads");
        i_ls_req = 1; i_ls_addr = 64'h7000;
        got = 0; cyc = 0; lastValid = -100; prevReq = 0;
        while (got < 5 && cyc < 50) begin
            i_mem_valid = o_mem_req;
            i_mem_rdata = 64'(cyc);
            @(negedge i_clk);
            if (o_mem_req && !prevReq && got > 0) begin
                checkOutput($sformatf("lsGap%0d", got), 64'(cyc - lastValid), 64'd2);
            end
            prevReq = o_mem_req;
            if (o_ls_valid) begin
                got++;
                lastValid = cyc;
            end
            cyc++;
            step();
        end
        if (got < 5) begin
            vecCount++;
            missCount++;
            $display("[TB] FAIL lsLoop_timeout: got %0d loads, expected 5", got);
        end
        clearInputs();
        runArbitration("afterLs", 5, 16'b0000_0000_0001_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
